pp_buffer_sched: RTL and testbench

Job-level scheduler in front of the ping-pong DDR-to-BRAM read path. It accepts one large read job as a DDR start address and a total beat count. It splits the job into bank-sized chunks, alternates them between BRAM bank 0 and bank 1, and issues rd_start requests to the read engine. It also tracks bank ownership, so no bank is refilled until the downstream consumer releases it.

---
 rtl/pp_buffer_sched.sv | 192 +++++++++++++++++++
 tb/tb_pp_buffer_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_buffer_sched.sv
// Job scheduler for the ping-pong DDR-to-BRAM read path: splits a read job into bank chunks.
// Optional stall counters are enabled by defining PP_BUFFER_SCHED_PERF_EN.
//
// state     | meaning
// IDLE      | no job; job_start is validated here
// WAIT_BANK | chunk computed, waiting for the target bank to be released
// ISSUE     | chunk registered, waiting for rd_ready to pulse rd_start
// WAIT_DONE | read engine busy filling the target bank
module pp_buffer_sched #(
  parameter int DDR_ADDR_WIDTH  = 29,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int NUM_BURST_WIDTH = 8,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int BURST_BEATS     = 16,
  parameter int BANK_BEATS      = 1024,
  parameter int BEAT_BYTES      = 8,
  parameter int TOTAL_WIDTH     = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_start,
  input  logic [DDR_ADDR_WIDTH-1:0]  job_addr,
  input  logic [TOTAL_WIDTH-1:0]     job_beats,
  output logic                       job_busy,
  output logic                       job_done,
  output logic                       job_err,
  output logic                       rd_start,
  output logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
  output logic [NUM_BURST_WIDTH-1:0] rd_num_burst,
  output logic [DDR_ADDR_WIDTH-1:0]  rd_start_addr,
  output logic [BRAM_ADDR_WIDTH-1:0] rd_start_bram_addr,
  output logic                       rd_bank,
  input  logic                       rd_ready,
  input  logic                       rd_done,
  output logic [1:0]                 bank_full,
  output logic [BRAM_ADDR_WIDTH:0]   bank0_beats,
  output logic [BRAM_ADDR_WIDTH:0]   bank1_beats,
  input  logic [1:0]                 bank_release
`ifdef PP_BUFFER_SCHED_PERF_EN
  ,
  output logic [31:0]                stall_bank_cycles,
  output logic [31:0]                stall_rd_cycles
`endif
);

  localparam int BW = BRAM_ADDR_WIDTH + 1;
  localparam logic [TOTAL_WIDTH-1:0]    BEAT_MASK  = TOTAL_WIDTH'(BURST_BEATS - 1);
  localparam logic [DDR_ADDR_WIDTH-1:0] ALIGN_MASK = DDR_ADDR_WIDTH'(BURST_BEATS * BEAT_BYTES - 1);
  localparam logic [TOTAL_WIDTH-1:0]    BANK_MAX   = TOTAL_WIDTH'(BANK_BEATS);

  typedef enum logic [1:0] {IDLE, WAIT_BANK, ISSUE, WAIT_DONE} state_t;

  state_t state, state_nxt;

  logic [DDR_ADDR_WIDTH-1:0] addr_q;
  logic [TOTAL_WIDTH-1:0]    remaining;
  logic [TOTAL_WIDTH-1:0]    chunk;
  logic                      ptr;
  logic                      job_ok;
  logic                      accept;
  logic                      reject;
  logic                      bank_go;
  logic                      chunk_done;
  logic [BW-1:0]             bank_beats_q [2];

  assign chunk  = (remaining > BANK_MAX) ? BANK_MAX : remaining;
  assign job_ok = (job_beats != '0) && ((job_beats & BEAT_MASK) == '0) &&
                  ((job_addr & ALIGN_MASK) == '0);

  assign job_busy           = (state != IDLE);
  assign rd_burst_len       = BURST_LEN_WIDTH'(BURST_BEATS - 1);
  assign rd_start_bram_addr = '0;
  assign bank0_beats        = bank_beats_q[0];
  assign bank1_beats        = bank_beats_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rd_start   = 1'b0;
    job_done   = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    bank_go    = 1'b0;
    chunk_done = 1'b0;
    case (state)
      IDLE: begin
        if (job_start) begin
          if (job_ok) begin
            accept    = 1'b1;
            state_nxt = WAIT_BANK;
          end else begin
            reject = 1'b1;
          end
        end
      end
      WAIT_BANK: begin
        if (!bank_full[ptr]) begin
          bank_go   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (rd_ready) begin
          rd_start  = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (rd_done) begin
          chunk_done = 1'b1;
          if (remaining == chunk) begin
            job_done  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_BANK;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      remaining     <= '0;
      ptr           <= 1'b0;
      job_err       <= 1'b0;
      rd_num_burst  <= '0;
      rd_start_addr <= '0;
      rd_bank       <= 1'b0;
    end else begin
      job_err <= reject;
      if (accept) begin
        addr_q    <= job_addr;
        remaining <= job_beats;
      end
      if (bank_go) begin
        rd_num_burst  <= NUM_BURST_WIDTH'(chunk / TOTAL_WIDTH'(BURST_BEATS));
        rd_start_addr <= addr_q;
        rd_bank       <= ptr;
      end
      // Address wraps modulo 2^DDR_ADDR_WIDTH by truncation.
      if (chunk_done) begin
        addr_q    <= addr_q + DDR_ADDR_WIDTH'(chunk * BEAT_BYTES);
        remaining <= remaining - chunk;
        ptr       <= ~ptr;
      end
    end
  end

  // A fill completing in the same cycle as a release of that bank wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full       <= '0;
      bank_beats_q[0] <= '0;
      bank_beats_q[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (chunk_done && (ptr == 1'(b))) begin
          bank_full[b]    <= 1'b1;
          bank_beats_q[b] <= BW'(chunk);
        end else if (bank_release[b] && bank_full[b]) begin
          bank_full[b]    <= 1'b0;
          bank_beats_q[b] <= '0;
        end
      end
    end
  end

`ifdef PP_BUFFER_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_bank_cycles <= '0;
      stall_rd_cycles   <= '0;
    end else if (accept) begin
      stall_bank_cycles <= '0;
      stall_rd_cycles   <= '0;
    end else begin
      if ((state == WAIT_BANK) && bank_full[ptr] && (stall_bank_cycles != '1))
        stall_bank_cycles <= stall_bank_cycles + 32'd1;
      if ((state == ISSUE) && !rd_ready && (stall_rd_cycles != '1))
        stall_rd_cycles <= stall_rd_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pp_buffer_sched.sv
// Directed self-checking bench for pp_buffer_sched: chunking, bank back-pressure,
// job rejection, rd_ready stall, reset abandonment and fill/release collision.
module tb_pp_buffer_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_start;
  logic [28:0] job_addr;
  logic [19:0] job_beats;
  logic        job_busy, job_done, job_err, rd_start;
  logic [7:0]  rd_burst_len, rd_num_burst;
  logic [28:0] rd_start_addr;
  logic [9:0]  rd_start_bram_addr;
  logic        rd_bank;
  logic        rd_ready, rd_done;
  logic [1:0]  bank_full;
  logic [10:0] bank0_beats, bank1_beats;
  logic [1:0]  bank_release;
`ifdef PP_BUFFER_SCHED_PERF_EN
  logic [31:0] stall_bank_cycles, stall_rd_cycles;
`endif

  int checks   = 0;
  int failures = 0;
  logic seen;

  pp_buffer_sched dut (
    .clk(clk), .rst(rst),
    .job_start(job_start), .job_addr(job_addr), .job_beats(job_beats),
    .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
    .rd_start(rd_start), .rd_burst_len(rd_burst_len), .rd_num_burst(rd_num_burst),
    .rd_start_addr(rd_start_addr), .rd_start_bram_addr(rd_start_bram_addr),
    .rd_bank(rd_bank), .rd_ready(rd_ready), .rd_done(rd_done),
    .bank_full(bank_full), .bank0_beats(bank0_beats), .bank1_beats(bank1_beats),
    .bank_release(bank_release)
`ifdef PP_BUFFER_SCHED_PERF_EN
    , .stall_bank_cycles(stall_bank_cycles), .stall_rd_cycles(stall_rd_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; job_start = 1'b0; job_addr = '0; job_beats = '0;
    rd_ready = 1'b1; rd_done = 1'b0; bank_release = 2'b00;
    tick(); tick();
    chk("rst_busy", job_busy, 0);
    chk("rst_burst_len", rd_burst_len, 15);
    chk("rst_rd_start", rd_start, 0);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_num_burst", rd_num_burst, 0);
    chk("rst_bram_addr", rd_start_bram_addr, 0);
    rst = 1'b0;
    tick();

    // 2048 beats at 0: two full chunks, bank 0 then bank 1
    job_start = 1'b1; job_addr = 29'h0; job_beats = 20'd2048;
    tick();
    job_start = 1'b0;
    chk("t1_busy", job_busy, 1);
    tick();
    chk("t1_c1_start", rd_start, 1);
    chk("t1_c1_num", rd_num_burst, 64);
    chk("t1_c1_addr", rd_start_addr, 29'h0);
    chk("t1_c1_bank", rd_bank, 0);
    tick();
    chk("t1_c1_start_one", rd_start, 0);
    rd_done = 1'b1;
    #1 chk("t1_c1_no_done", job_done, 0);
    tick();
    rd_done = 1'b0;
    chk("t1_full_a", bank_full, 2'b01);
    chk("t1_b0_beats", bank0_beats, 1024);
    tick();
    chk("t1_c2_start", rd_start, 1);
    chk("t1_c2_num", rd_num_burst, 64);
    chk("t1_c2_addr", rd_start_addr, 29'h2000);
    chk("t1_c2_bank", rd_bank, 1);
    tick();
    rd_done = 1'b1;
    #1 chk("t1_done", job_done, 1);
    tick();
    rd_done = 1'b0;
    chk("t1_idle_busy", job_busy, 0);
    chk("t1_full_b", bank_full, 2'b11);
    chk("t1_b1_beats", bank1_beats, 1024);

    // release both, then 1040 beats: chunks of 1024 and 16
    bank_release = 2'b11;
    tick();
    bank_release = 2'b00;
    chk("rel_both", bank_full, 2'b00);
    chk("rel_b0_beats", bank0_beats, 0);
    job_start = 1'b1; job_addr = 29'h10000; job_beats = 20'd1040;
    tick();
    job_start = 1'b0;
    tick();
    chk("t2_c1_start", rd_start, 1);
    chk("t2_c1_num", rd_num_burst, 64);
    chk("t2_c1_addr", rd_start_addr, 29'h10000);
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tick();
    chk("t2_c2_start", rd_start, 1);
    chk("t2_c2_num", rd_num_burst, 1);
    chk("t2_c2_addr", rd_start_addr, 29'h12000);
    chk("t2_c2_bank", rd_bank, 1);
    tick();
    rd_done = 1'b1;
    #1 chk("t2_done", job_done, 1);
    tick();
    rd_done = 1'b0;
    chk("t2_b1_beats", bank1_beats, 16);
    chk("t2_b0_beats", bank0_beats, 1024);

    // 3072 beats with no release: hold in WAIT_BANK after two chunks
    bank_release = 2'b11;
    tick();
    bank_release = 2'b00;
    job_start = 1'b1; job_addr = 29'h0; job_beats = 20'd3072;
    tick();
    job_start = 1'b0;
    tick();
    chk("t3_c1_bank", rd_bank, 0);
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tick();
    chk("t3_c2_start", rd_start, 1);
    chk("t3_c2_addr", rd_start_addr, 29'h2000);
    tick();
    rd_done = 1'b1;
    #1 chk("t3_c2_no_done", job_done, 0);
    tick();
    rd_done = 1'b0;
    seen = 1'b0;
    job_start = 1'b1; job_beats = 20'd24;
    for (int i = 0; i < 6; i++) begin
      if (rd_start !== 1'b0 || job_err !== 1'b0) seen = 1'b1;
      tick();
      job_start = 1'b0;
    end
    chk("t3_hold_quiet", seen, 0);
    chk("t3_hold_busy", job_busy, 1);
    chk("t3_hold_full", bank_full, 2'b11);
    bank_release = 2'b01;
    tick();
    bank_release = 2'b00;
    chk("t3_rel_full", bank_full, 2'b10);
    chk("t3_rel_no_start", rd_start, 0);
    tick();
    chk("t3_c3_start", rd_start, 1);
    chk("t3_c3_addr", rd_start_addr, 29'h4000);
    chk("t3_c3_bank", rd_bank, 0);
    chk("t3_c3_num", rd_num_burst, 64);
    tick();
    // fill and release of bank 0 in the same cycle: fill wins
    rd_done = 1'b1; bank_release = 2'b01;
    #1 chk("t3_done", job_done, 1);
    tick();
    rd_done = 1'b0; bank_release = 2'b00;
    chk("t3_set_wins", bank_full, 2'b11);
    chk("t3_set_beats", bank0_beats, 1024);
    chk("t3_idle", job_busy, 0);

    // rejected jobs
    bank_release = 2'b11;
    tick();
    bank_release = 2'b00;
    job_start = 1'b1; job_addr = 29'h0; job_beats = 20'd24;
    tick();
    job_start = 1'b0;
    chk("e1_err", job_err, 1);
    chk("e1_busy", job_busy, 0);
    tick();
    chk("e1_err_pulse", job_err, 0);
    job_start = 1'b1; job_addr = 29'h40; job_beats = 20'd16;
    tick();
    job_start = 1'b0;
    chk("e2_err", job_err, 1);
    chk("e2_busy", job_busy, 0);
    chk("e2_no_start", rd_start, 0);
    job_start = 1'b1; job_addr = 29'h0; job_beats = 20'd0;
    tick();
    job_start = 1'b0;
    chk("e3_err", job_err, 1);
    tick();

    // rd_ready low in ISSUE, then reset mid WAIT_DONE (ptr is 1 here)
    rd_ready = 1'b0;
    job_start = 1'b1; job_addr = 29'h80; job_beats = 20'd16;
    tick();
    job_start = 1'b0;
    chk("s_err_clear", job_err, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_start !== 1'b0) seen = 1'b1;
    end
    chk("s_no_start_while_busy_rd", seen, 0);
    rd_ready = 1'b1;
    #1 chk("s_start", rd_start, 1);
    chk("s_bank", rd_bank, 1);
    chk("s_num", rd_num_burst, 1);
    chk("s_addr", rd_start_addr, 29'h80);
    tick();
    chk("s_start_one", rd_start, 0);
    rst = 1'b1;
    #1 chk("r_busy", job_busy, 0);
    chk("r_addr", rd_start_addr, 0);
    chk("r_num", rd_num_burst, 0);
    chk("r_bank", rd_bank, 0);
    tick();
    rst = 1'b0;
    tick();
    rd_done = 1'b1;
    #1 chk("r_no_done", job_done, 0);
    tick();
    rd_done = 1'b0;
    chk("r_full_after", bank_full, 0);
    chk("r_b1_beats", bank1_beats, 0);
    chk("r_idle", job_busy, 0);
    job_start = 1'b1; job_addr = 29'h0; job_beats = 20'd16;
    tick();
    job_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rd_start === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("r_restart_seen", seen, 1);
    chk("r_restart_bank", rd_bank, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
